mc_sequencer: RTL and testbench

- Multi-cycle control sequencer for the MIPS datapath.
- Steps each instruction through fetch, decode, execute, memory and write-back states.
- Drives the datapath strobes and mux selects: PC write, IR load, register-file write, ALU source/op, memory request.
- Replaces single-cycle combinational control, so one shared memory port serves both instruction and data accesses, with a ready handshake and a timeout watchdog.

---
 rtl/mc_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_mc_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_sequencer.sv
// Multi-cycle MIPS control sequencer sharing one memory port for fetch and data, with a wait watchdog.
// Build option: define MC_ILLEGAL_TRAP_EN to halt on illegal instructions instead of treating them as NOPs.
module mc_sequencer #(
   parameter int unsigned WAIT_LIMIT = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       iord,
   output logic       ir_we,
   output logic       pc_we,
   output logic [1:0] pc_src,
   output logic       reg_we,
   output logic       regdst,
   output logic       mem2reg,
   output logic       alusrc,
   output logic       extop,
   output logic [3:0] aluop,
   output logic [2:0] state,
   output logic       bus_error,
   output logic       illegal
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      C_NONE  = 3'd0,
      C_RTYPE = 3'd1,
      C_LW    = 3'd2,
      C_SW    = 3'd3,
      C_BEQ   = 3'd4,
      C_ADDI  = 3'd5,
      C_J     = 3'd6,
      C_ILL   = 3'd7
   } cls_t;

   localparam logic [7:0] LIMIT_M1 = 8'(WAIT_LIMIT - 1);

   state_t     state_q, state_d;
   cls_t       cls_q, cls_d, dec_cls;
   logic [3:0] alu_q, alu_d, dec_alu;
   logic [7:0] cnt_q, cnt_d;
   logic       bus_error_q, bus_error_d;
   logic       illegal_q, illegal_d;

   logic       mem_req_c, mem_we_c, iord_c, ir_we_c, pc_we_c;
   logic [1:0] pc_src_c;
   logic       reg_we_c, regdst_c, mem2reg_c, alusrc_c, extop_c;
   logic [3:0] aluop_c;
   logic       ill_pulse_c;
   logic       timeout_c;

   always_comb begin
      dec_cls = C_ILL;
      dec_alu = 4'b0010;
      case (op)
         6'h00: begin
            dec_cls = C_RTYPE;
            case (funct)
               6'h20:   dec_alu = 4'b0010;
               6'h22:   dec_alu = 4'b0110;
               6'h24:   dec_alu = 4'b0000;
               6'h25:   dec_alu = 4'b0001;
               6'h2A:   dec_alu = 4'b0111;
               default: dec_cls = C_ILL;
            endcase
         end
         6'h23:   dec_cls = C_LW;
         6'h2B:   dec_cls = C_SW;
         6'h04:   dec_cls = C_BEQ;
         6'h08:   dec_cls = C_ADDI;
         6'h02:   dec_cls = C_J;
         default: dec_cls = C_ILL;
      endcase
   end

   // Watchdog trips only when the last allowed wait cycle also lacks mem_ready.
   assign timeout_c = (state_q == S_FETCH || state_q == S_MEM) && !mem_ready && (cnt_q == LIMIT_M1);

   always_comb begin
      state_d     = state_q;
      cls_d       = cls_q;
      alu_d       = alu_q;
      cnt_d       = 8'd0;
      bus_error_d = bus_error_q;
      illegal_d   = illegal_q;
      mem_req_c   = 1'b0;
      mem_we_c    = 1'b0;
      iord_c      = 1'b0;
      ir_we_c     = 1'b0;
      pc_we_c     = 1'b0;
      pc_src_c    = 2'd0;
      reg_we_c    = 1'b0;
      regdst_c    = 1'b0;
      mem2reg_c   = 1'b0;
      alusrc_c    = 1'b0;
      extop_c     = 1'b0;
      aluop_c     = 4'b0000;
      ill_pulse_c = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req_c = 1'b1;
            if (mem_ready) begin
               ir_we_c = 1'b1;
               pc_we_c = 1'b1;
               state_d = S_DECODE;
            end else if (timeout_c) begin
               state_d     = S_HALT;
               bus_error_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_DECODE: begin
            cls_d = dec_cls;
            alu_d = dec_alu;
            case (dec_cls)
               C_J: begin
                  pc_we_c  = 1'b1;
                  pc_src_c = 2'd2;
                  state_d  = S_FETCH;
               end
               C_ILL: begin
                  ill_pulse_c = 1'b1;
`ifdef MC_ILLEGAL_TRAP_EN
                  illegal_d = 1'b1;
                  state_d   = S_HALT;
`else
                  state_d   = S_FETCH;
`endif
               end
               default: state_d = S_EXEC;
            endcase
         end
         S_EXEC: begin
            case (cls_q)
               C_RTYPE: begin
                  aluop_c = alu_q;
                  state_d = S_WB;
               end
               C_ADDI, C_LW, C_SW: begin
                  alusrc_c = 1'b1;
                  extop_c  = 1'b1;
                  aluop_c  = 4'b0010;
                  state_d  = (cls_q == C_ADDI) ? S_WB : S_MEM;
               end
               C_BEQ: begin
                  aluop_c  = 4'b0110;
                  pc_src_c = 2'd1;
                  pc_we_c  = zero;
                  state_d  = S_FETCH;
               end
               default: state_d = S_FETCH;
            endcase
         end
         S_MEM: begin
            mem_req_c = 1'b1;
            iord_c    = 1'b1;
            mem_we_c  = (cls_q == C_SW);
            if (mem_ready) begin
               state_d = (cls_q == C_LW) ? S_WB : S_FETCH;
            end else if (timeout_c) begin
               state_d     = S_HALT;
               bus_error_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_WB: begin
            reg_we_c  = 1'b1;
            regdst_c  = (cls_q == C_RTYPE);
            mem2reg_c = (cls_q == C_LW);
            state_d   = S_FETCH;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_FETCH;
         cls_q       <= C_NONE;
         alu_q       <= 4'b0000;
         cnt_q       <= 8'd0;
         bus_error_q <= 1'b0;
         illegal_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cls_q       <= cls_d;
         alu_q       <= alu_d;
         cnt_q       <= cnt_d;
         bus_error_q <= bus_error_d;
         illegal_q   <= illegal_d;
      end
   end

   // Strobes are held low for as long as rst is asserted, even mid-access.
   assign mem_req   = mem_req_c & ~rst;
   assign mem_we    = mem_we_c & ~rst;
   assign iord      = iord_c & ~rst;
   assign ir_we     = ir_we_c & ~rst;
   assign pc_we     = pc_we_c & ~rst;
   assign pc_src    = rst ? 2'd0 : pc_src_c;
   assign reg_we    = reg_we_c & ~rst;
   assign regdst    = regdst_c & ~rst;
   assign mem2reg   = mem2reg_c & ~rst;
   assign alusrc    = alusrc_c & ~rst;
   assign extop     = extop_c & ~rst;
   assign aluop     = rst ? 4'd0 : aluop_c;
   assign state     = state_q;
   assign bus_error = bus_error_q;
   assign illegal   = illegal_q | (ill_pulse_c & ~rst);

endmodule

// File: tb/tb_mc_sequencer.sv
// Randomized scoreboard bench for mc_sequencer: per-instruction cycle traces are expanded from the ISA rules.
// Honours MC_ILLEGAL_TRAP_EN the same way as the design.
module tb_mc_sequencer;

   localparam int WL = 4;
   localparam int ST_F = 0, ST_D = 1, ST_X = 2, ST_M = 3, ST_W = 4, ST_H = 5;
   localparam int K_R = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_ADDI = 4, K_J = 5, K_ILL = 6;

   typedef struct packed {
      logic [2:0] st;
      logic       mem_req, mem_we, iord, ir_we, pc_we;
      logic [1:0] pc_src;
      logic       reg_we, regdst, mem2reg, alusrc, extop;
      logic [3:0] aluop;
      logic       be, ill;
   } obs_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] op = 6'd0, funct = 6'd0;
   logic       zero = 1'b0, mem_ready = 1'b0;
   logic       mem_req, mem_we, iord, ir_we, pc_we, reg_we, regdst, mem2reg, alusrc, extop;
   logic [1:0] pc_src;
   logic [3:0] aluop;
   logic [2:0] state;
   logic       bus_error, illegal;

   logic [20:0] exp_q[$];
   int          errors = 0;
   int          checks = 0;
   logic        exp_be = 1'b0;
   logic        exp_ill = 1'b0;

   // ---------------- clock / DUT ----------------
   always #5 clk = ~clk;

   mc_sequencer #(.WAIT_LIMIT(WL)) dut (
      .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we), .pc_we(pc_we),
      .pc_src(pc_src), .reg_we(reg_we), .regdst(regdst), .mem2reg(mem2reg),
      .alusrc(alusrc), .extop(extop), .aluop(aluop), .state(state),
      .bus_error(bus_error), .illegal(illegal)
   );

   // ---------------- reference rules ----------------
   function automatic int cls_of(input logic [5:0] o, input logic [5:0] f);
      case (o)
         6'h00:   return (f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25 || f == 6'h2A) ? K_R : K_ILL;
         6'h23:   return K_LW;
         6'h2B:   return K_SW;
         6'h04:   return K_BEQ;
         6'h08:   return K_ADDI;
         6'h02:   return K_J;
         default: return K_ILL;
      endcase
   endfunction

   function automatic logic [3:0] rtype_alu(input logic [5:0] f);
      case (f)
         6'h20:   return 4'b0010;
         6'h22:   return 4'b0110;
         6'h24:   return 4'b0000;
         6'h25:   return 4'b0001;
         default: return 4'b0111;
      endcase
   endfunction

   function automatic obs_t base(input int st);
      obs_t e;
      e     = '0;
      e.st  = 3'(st);
      e.be  = exp_be;
      e.ill = exp_ill;
      return e;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic step(input logic rdy, input logic z, input obs_t e);
      mem_ready = rdy;
      zero      = z;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int prev, input bit chk);
      rst       = 1'b1;
      mem_ready = 1'($urandom_range(0, 1));
      if (chk) exp_q.push_back(base(prev));
      @(posedge clk);
      #1;
      exp_be  = 1'b0;
      exp_ill = 1'b0;
      exp_q.push_back(base(ST_F));
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic halt_phase();
      for (int i = 0; i < 3; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), base(ST_H));
      do_reset(ST_H, 1'b1);
   endtask

   // Wait cycles of a memory access; reports whether the watchdog expired.
   task automatic mem_wait(input obs_t e, input int waits, output bit to);
      int n;
      n = (waits >= WL) ? WL : waits;
      for (int i = 0; i < n; i++) step(1'b0, 1'($urandom_range(0, 1)), e);
      to = (waits >= WL);
      if (to) exp_be = 1'b1;
   endtask

   task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                            input int fw, input int mw);
      obs_t e;
      bit   to;
      int   k;
      op    = o;
      funct = f;
      k     = cls_of(o, f);
      e = base(ST_F);
      e.mem_req = 1'b1;
      mem_wait(e, fw, to);
      if (to) begin
         halt_phase();
         return;
      end
      e.ir_we = 1'b1;
      e.pc_we = 1'b1;
      step(1'b1, 1'($urandom_range(0, 1)), e);
      e = base(ST_D);
      if (k == K_J) begin
         e.pc_we  = 1'b1;
         e.pc_src = 2'd2;
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e);
         return;
      end
      if (k == K_ILL) begin
         e.ill = 1'b1;
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e);
`ifdef MC_ILLEGAL_TRAP_EN
         exp_ill = 1'b1;
         halt_phase();
`endif
         return;
      end
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e);
      e = base(ST_X);
      if (k == K_BEQ) begin
         e.aluop  = 4'b0110;
         e.pc_src = 2'd1;
         e.pc_we  = z;
         step(1'($urandom_range(0, 1)), z, e);
         return;
      end
      if (k == K_R) begin
         e.aluop = rtype_alu(f);
      end else begin
         e.alusrc = 1'b1;
         e.extop  = 1'b1;
         e.aluop  = 4'b0010;
      end
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e);
      if (k == K_LW || k == K_SW) begin
         e = base(ST_M);
         e.mem_req = 1'b1;
         e.iord    = 1'b1;
         e.mem_we  = (k == K_SW);
         mem_wait(e, mw, to);
         if (to) begin
            halt_phase();
            return;
         end
         step(1'b1, 1'($urandom_range(0, 1)), e);
         if (k == K_SW) return;
      end
      e = base(ST_W);
      e.reg_we  = 1'b1;
      e.regdst  = (k == K_R);
      e.mem2reg = (k == K_LW);
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e);
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      obs_t a, e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {state, mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_we, regdst, mem2reg,
              alusrc, extop, aluop, bus_error, illegal};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL cycle_check t=%0t state got=%0d exp=%0d outputs got=%h exp=%h",
                     $time, a.st, e.st, a, e);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [5:0] ops[7];
      logic [5:0] fns[5];
      logic [5:0] ro, rf;
      int         fw, mw;
      ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02, 6'h3F};
      fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
      @(posedge clk);
      #1;
      do_reset(ST_F, 1'b0);

      run_instr(6'h00, 6'h20, 1'b0, 0, 0);
      run_instr(6'h23, 6'h00, 1'b0, 0, 3);
      run_instr(6'h04, 6'h00, 1'b1, 0, 0);
      run_instr(6'h04, 6'h00, 1'b0, 0, 0);
      run_instr(6'h2B, 6'h11, 1'b0, 1, 2);
      run_instr(6'h08, 6'h05, 1'b0, 2, 0);
      run_instr(6'h02, 6'h00, 1'b0, 0, 0);
      for (int i = 0; i < 5; i++) run_instr(6'h00, fns[i], 1'b0, 0, 0);
      run_instr(6'h00, 6'h20, 1'b0, WL, 0);
      run_instr(6'h00, 6'h20, 1'b0, WL - 1, 0);
      run_instr(6'h23, 6'h00, 1'b0, 0, WL - 1);
      run_instr(6'h2B, 6'h00, 1'b0, 0, WL + 2);
      run_instr(6'h3F, 6'h00, 1'b0, 0, 0);
      run_instr(6'h00, 6'h21, 1'b0, 0, 0);

      // reset asserted while a fetch is still waiting
      op = 6'h00;
      funct = 6'h20;
      for (int i = 0; i < 2; i++) begin
         obs_t e;
         e = base(ST_F);
         e.mem_req = 1'b1;
         step(1'b0, 1'b0, e);
      end
      do_reset(ST_F, 1'b1);
      run_instr(6'h00, 6'h20, 1'b0, WL - 1, 0);

      for (int n = 0; n < 300; n++) begin
         ro = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 6)];
         rf = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : fns[$urandom_range(0, 4)];
         fw = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, WL + 1));
         mw = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, WL + 1));
         run_instr(ro, rf, 1'($urandom_range(0, 1)), fw, mw);
      end

      @(posedge clk);
      @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_check pending got=%0d exp=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached got=running exp=finished");
      $fatal(1, "bench time limit");
   end

endmodule
